// File: rtl/fft_power_framer.sv
// fft_power_framer: turns the streaming complex FFT output into per-bin power
// |X|^2 for bins 0..I-1, stores whole frames in a two-bank ping-pong store and
// replays each completed frame as one gap-free I-word burst. Bursts are paced
// by the downstream completion pulse so only one frame is in flight at a time.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   fft_in_valid/re/im/last   input bin stream (signed re/im, last = final bin)
//   formant_done              downstream finished the previous frame
//   fft_valid, fft_data       output burst, bin 0 first, data held 0 when idle
//   frame_dropped             pulse: frame ignored, both banks occupied
//   frame_short               pulse: frame ended with fewer than I bins
//
// Build option: define POWER_SMOOTH_EN to write (3*h + p) >> 2 using a per-bin
// history instead of raw power (adds one pipeline stage and a post-reset
// history clear during which input beats are discarded).
module fft_power_framer #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned IN_WIDTH  = 16,
   parameter int unsigned I         = 160
) (
   input  logic                       clk_in,
   input  logic                       rst_in,
   input  logic                       fft_in_valid,
   input  logic signed [IN_WIDTH-1:0] fft_in_re,
   input  logic signed [IN_WIDTH-1:0] fft_in_im,
   input  logic                       fft_in_last,
   input  logic                       formant_done,
   output logic                       fft_valid,
   output logic [BIT_WIDTH-1:0]       fft_data,
   output logic                       frame_dropped,
   output logic                       frame_short
);

   localparam int unsigned CW = $clog2(I + 1);
   localparam int unsigned AW = $clog2(I);
   localparam int unsigned MW = 2 * IN_WIDTH;
   localparam int unsigned PW = 2 * IN_WIDTH + 1;

   typedef enum logic [1:0] {S_IDLE, S_PREFETCH, S_BURST} state_t;

   logic [BIT_WIDTH-1:0] mem_a [I];
   logic [BIT_WIDTH-1:0] mem_b [I];

   logic [CW-1:0]        cnt_q;
   logic                 drop_q;
   logic                 wr_bank_q;
   logic [1:0]           full_q;
   logic                 in_ok;

   logic                 s1_we_q, s1_cmp_q, s1_bank_q;
   logic [AW-1:0]        s1_addr_q;
   logic [MW-1:0]        re_sq_q, im_sq_q;

   logic                 wr_en, wr_cmp, wr_bank;
   logic [AW-1:0]        wr_addr;
   logic [BIT_WIDTH-1:0] wr_data;

   state_t               state_q;
   logic                 rd_bank_q, ds_free_q, issue_q, rdv_q;
   logic [AW-1:0]        rd_addr_q, out_cnt_q;
   logic [BIT_WIDTH-1:0] rd_data_q;

   // Input beat classification; the drop decision is latched on the first beat.
   logic                 beat, first_beat, drop_now, wr_now, complete, short_now, dropped_now;
   logic signed [MW-1:0] re_ext, im_ext;
   always_comb begin
      beat        = fft_in_valid && in_ok;
      first_beat  = (cnt_q == '0);
      drop_now    = first_beat ? full_q[wr_bank_q] : drop_q;
      wr_now      = beat && !drop_now && (cnt_q < CW'(I));
      complete    = beat && fft_in_last && !drop_now && (cnt_q >= CW'(I - 1));
      short_now   = beat && fft_in_last && !drop_now && (cnt_q < CW'(I - 1));
      dropped_now = beat && fft_in_last && drop_now;
      re_ext      = MW'(fft_in_re);
      im_ext      = MW'(fft_in_im);
   end

   // Bin counter, bank selection and first (multiply) pipeline stage.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q         <= '0;
         drop_q        <= 1'b0;
         wr_bank_q     <= 1'b0;
         s1_we_q       <= 1'b0;
         s1_cmp_q      <= 1'b0;
         frame_dropped <= 1'b0;
         frame_short   <= 1'b0;
      end else begin
         frame_dropped <= dropped_now;
         frame_short   <= short_now;
         s1_we_q       <= wr_now;
         s1_cmp_q      <= complete;
         s1_bank_q     <= wr_bank_q;
         s1_addr_q     <= AW'(cnt_q);
         re_sq_q       <= re_ext * re_ext;
         im_sq_q       <= im_ext * im_ext;
         if (beat) begin
            if (fft_in_last) begin
               cnt_q  <= '0;
               drop_q <= 1'b0;
            end else begin
               if (cnt_q < CW'(I)) cnt_q <= cnt_q + CW'(1);
               if (first_beat) drop_q <= drop_now;
            end
         end
         // The bank id travels with the pipeline, so the pointer can move now.
         if (complete) wr_bank_q <= ~wr_bank_q;
      end
   end

   // Sum of squares, saturated to BIT_WIDTH.
   logic [PW-1:0]        sum;
   logic [BIT_WIDTH-1:0] pow;
   always_comb begin
      sum = PW'(re_sq_q) + PW'(im_sq_q);
      pow = ((sum >> BIT_WIDTH) != '0) ? '1 : BIT_WIDTH'(sum);
   end

`ifdef POWER_SMOOTH_EN
   logic [BIT_WIDTH-1:0] hist [I];
   logic                 s2_we_q, s2_cmp_q, s2_bank_q;
   logic [AW-1:0]        s2_addr_q;
   logic [BIT_WIDTH-1:0] s2_p_q, s2_h_q, h_new;
   logic [BIT_WIDTH+1:0] acc, acc_sh;
   logic                 clr_busy_q;
   logic [AW-1:0]        clr_cnt_q;

   // h' = (3h + p) >> 2 at two extra bits of headroom.
   always_comb begin
      acc     = ({2'b00, s2_h_q} << 1) + {2'b00, s2_h_q} + {2'b00, s2_p_q};
      acc_sh  = acc >> 2;
      h_new   = (acc_sh[BIT_WIDTH+1:BIT_WIDTH] != 2'b00) ? '1 : acc_sh[BIT_WIDTH-1:0];
      wr_en   = s2_we_q;
      wr_cmp  = s2_cmp_q;
      wr_bank = s2_bank_q;
      wr_addr = s2_addr_q;
      wr_data = h_new;
      in_ok   = !clr_busy_q;
   end

   // Extra stage: register power and fetch the bin's history.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s2_we_q    <= 1'b0;
         s2_cmp_q   <= 1'b0;
         clr_busy_q <= 1'b1;
         clr_cnt_q  <= '0;
      end else begin
         s2_we_q   <= s1_we_q;
         s2_cmp_q  <= s1_cmp_q;
         s2_bank_q <= s1_bank_q;
         s2_addr_q <= s1_addr_q;
         s2_p_q    <= pow;
         s2_h_q    <= hist[s1_addr_q];
         if (clr_busy_q) begin
            if (clr_cnt_q == AW'(I - 1)) clr_busy_q <= 1'b0;
            else                         clr_cnt_q  <= clr_cnt_q + AW'(1);
         end
      end
   end

   // History store: zeroed after reset, then tracks every written bin.
   always_ff @(posedge clk_in) begin
      if (clr_busy_q)  hist[clr_cnt_q] <= '0;
      else if (wr_en)  hist[wr_addr]   <= h_new;
   end
`else
   always_comb begin
      wr_en   = s1_we_q;
      wr_cmp  = s1_cmp_q;
      wr_bank = s1_bank_q;
      wr_addr = s1_addr_q;
      wr_data = pow;
      in_ok   = 1'b1;
   end
`endif

   // Ping-pong frame store.
   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         if (wr_bank) mem_b[wr_addr] <= wr_data;
         else         mem_a[wr_addr] <= wr_data;
      end
   end

   // Output FSM plus read pipeline: address issue, RAM data reg, output reg.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= S_IDLE;
         full_q    <= 2'b00;
         rd_bank_q <= 1'b0;
         ds_free_q <= 1'b1;
         issue_q   <= 1'b0;
         rd_addr_q <= '0;
         out_cnt_q <= '0;
         rdv_q     <= 1'b0;
         rd_data_q <= '0;
         fft_valid <= 1'b0;
         fft_data  <= '0;
      end else begin
         rdv_q     <= issue_q;
         if (issue_q) rd_data_q <= rd_bank_q ? mem_b[rd_addr_q] : mem_a[rd_addr_q];
         fft_valid <= rdv_q;
         fft_data  <= rdv_q ? rd_data_q : '0;
         if (issue_q) begin
            if (rd_addr_q == AW'(I - 1)) issue_q   <= 1'b0;
            else                         rd_addr_q <= rd_addr_q + AW'(1);
         end
         if (formant_done) ds_free_q <= 1'b1;
         // Completion and release always target different banks.
         if (wr_cmp) full_q[wr_bank] <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (ds_free_q && full_q[rd_bank_q]) begin
                  state_q   <= S_PREFETCH;
                  issue_q   <= 1'b1;
                  rd_addr_q <= '0;
                  ds_free_q <= 1'b0;
               end
            end
            S_PREFETCH: begin
               state_q   <= S_BURST;
               out_cnt_q <= '0;
            end
            S_BURST: begin
               if (out_cnt_q == AW'(I - 1)) begin
                  full_q[rd_bank_q] <= 1'b0;
                  rd_bank_q         <= ~rd_bank_q;
                  state_q           <= S_IDLE;
               end else begin
                  out_cnt_q <= out_cnt_q + AW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_power_framer.sv
module tb_fft_power_framer;
   localparam int unsigned BW = 32;
   localparam int unsigned IW = 16;
   localparam int unsigned NI = 160;

   logic                 clk_in = 1'b0;
   logic                 rst_in;
   logic                 fft_in_valid, fft_in_last, formant_done;
   logic signed [IW-1:0] fft_in_re, fft_in_im;
   logic                 fft_valid, frame_dropped, frame_short;
   logic [BW-1:0]        fft_data;
   logic                 v30, drop30, short30;
   logic [29:0]          d30;

   always #5 clk_in = ~clk_in;

   fft_power_framer #(.BIT_WIDTH(BW), .IN_WIDTH(IW), .I(NI)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .fft_in_valid(fft_in_valid),
      .fft_in_re(fft_in_re), .fft_in_im(fft_in_im), .fft_in_last(fft_in_last),
      .formant_done(formant_done), .fft_valid(fft_valid), .fft_data(fft_data),
      .frame_dropped(frame_dropped), .frame_short(frame_short));

   fft_power_framer #(.BIT_WIDTH(30), .IN_WIDTH(IW), .I(NI)) dut30 (
      .clk_in(clk_in), .rst_in(rst_in), .fft_in_valid(fft_in_valid),
      .fft_in_re(fft_in_re), .fft_in_im(fft_in_im), .fft_in_last(fft_in_last),
      .formant_done(formant_done), .fft_valid(v30), .fft_data(d30),
      .frame_dropped(drop30), .frame_short(short30));

   int     tests = 0, fails = 0;
   longint exp_q[$], exp30_q[$];
   longint last_burst[NI], last30[NI];
   longint hist32[NI], hist30[NI];
   int     run_len = 0, run30 = 0, bursts = 0, drop_cycles = 0, short_cycles = 0;
   bit     abort = 1'b0, stop_send = 1'b0;

   task automatic chk(string name, longint act, longint expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic longint power_of(int re, int im, int bw);
      longint p, m;
      p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      m = (longint'(1) << bw) - 1;
      return (p > m) ? m : p;
   endfunction

   function automatic longint smooth(longint h, longint p, int bw);
      longint v, m;
      v = (3 * h + p) >> 2;
      m = (longint'(1) << bw) - 1;
      return (v > m) ? m : v;
   endfunction

   function automatic void gen(int mode, int k, output int re, output int im);
      case (mode)
         0: begin re = k;            im = 0;          end
         1: begin re = -32768;       im = -32768;     end
         2: begin re = k + 1;        im = 2;          end
         3: begin re = -k;           im = k;          end
         4: begin re = 7;            im = 7;          end
         5: begin re = 32;           im = 0;          end
         6: begin re = k*200 - 16000; im = 300 - k*3; end
         default: begin re = k*37;   im = -k*91;      end
      endcase
   endfunction

   // Main-instance monitor: every word against the queue, idle data must be 0.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (fft_valid) begin
            if (!abort) begin
               if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
               else chk("burst_word", longint'(fft_data), exp_q.pop_front());
               if (run_len < NI) last_burst[run_len] = longint'(fft_data);
            end
            run_len++;
         end else begin
            chk("idle_data_zero", longint'(fft_data), 0);
            if (run_len != 0) begin
               if (!abort) chk("burst_length", run_len, NI);
               bursts++;
               run_len = 0;
            end
         end
         if (frame_dropped) drop_cycles++;
         if (frame_short)   short_cycles++;
      end
   end

   // 30-bit instance monitor.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (v30) begin
            if (!abort) begin
               if (exp30_q.size() == 0) chk("unexpected_word30", 1, 0);
               else chk("burst_word30", longint'(d30), exp30_q.pop_front());
               if (run30 < NI) last30[run30] = longint'(d30);
            end
            run30++;
         end else begin
            chk("idle_data_zero30", longint'(d30), 0);
            run30 = 0;
         end
      end
   end

   task automatic tick(int n);
      for (int i = 0; i < n; i++) begin @(posedge clk_in); #1; end
   endtask

   task automatic release_ds();
      formant_done = 1'b1; tick(1); formant_done = 1'b0;
   endtask

   task automatic clear_model();
      for (int k = 0; k < NI; k++) begin hist32[k] = 0; hist30[k] = 0; end
      exp_q.delete(); exp30_q.delete();
   endtask

   task automatic send_frame(int n, int mode, bit exp_drop);
      int re, im;
      longint p32, p30;
      longint v32[NI], v30a[NI];
      bit exp_short;
      for (int k = 0; k < n; k++) begin
         if (stop_send) begin fft_in_valid = 1'b0; fft_in_last = 1'b0; return; end
         gen(mode, k, re, im);
         fft_in_valid = 1'b1; fft_in_re = IW'(re); fft_in_im = IW'(im);
         fft_in_last  = (k == n - 1);
         if (!exp_drop && k < NI) begin
            p32 = power_of(re, im, BW);
            p30 = power_of(re, im, 30);
`ifdef POWER_SMOOTH_EN
            hist32[k] = smooth(hist32[k], p32, BW); v32[k]  = hist32[k];
            hist30[k] = smooth(hist30[k], p30, 30); v30a[k] = hist30[k];
`else
            v32[k] = p32; v30a[k] = p30;
`endif
         end
         tick(1);
      end
      fft_in_valid = 1'b0; fft_in_last = 1'b0;
      exp_short = !exp_drop && (n < NI);
      chk("frame_dropped", longint'(frame_dropped), longint'(exp_drop));
      chk("frame_short", longint'(frame_short), longint'(exp_short));
      chk("frame_dropped30", longint'(drop30), longint'(exp_drop));
      if (!exp_drop && n >= NI)
         for (int k = 0; k < NI; k++) begin exp_q.push_back(v32[k]); exp30_q.push_back(v30a[k]); end
   endtask

   task automatic wait_idle(int budget);
      int c = 0;
      while ((exp_q.size() != 0 || run_len != 0 || fft_valid) && c < budget) begin tick(1); c++; end
      chk("drain_in_budget", longint'(c < budget), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0, d0, s0, c;
      longint exp6[4];
      rst_in = 1'b1; fft_in_valid = 1'b0; fft_in_last = 1'b0; formant_done = 1'b0;
      fft_in_re = '0; fft_in_im = '0;
      clear_model();
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_fft_valid", longint'(fft_valid), 0);
      chk("rst_fft_data", longint'(fft_data), 0);
      chk("rst_frame_dropped", longint'(frame_dropped), 0);
      chk("rst_frame_short", longint'(frame_short), 0);
      rst_in = 1'b0;
      tick(200);

      // 512-bin ramp: only bins 0..159 come out, as k^2.
      b0 = bursts;
      send_frame(512, 0, 1'b0);
      wait_idle(1000);
      chk("t1_bursts", bursts - b0, 1);
`ifndef POWER_SMOOTH_EN
      chk("t1_bin0", last_burst[0], 0);
      chk("t1_bin7", last_burst[7], 49);
      chk("t1_bin159", last_burst[159], 25281);
`endif
      release_ds();

      // Most negative inputs: 2^31 at 32 bits, saturated at 30 bits.
      send_frame(160, 1, 1'b0);
      wait_idle(1000);
`ifndef POWER_SMOOTH_EN
      chk("t2_pow32", last_burst[0], 64'h8000_0000);
      chk("t2_pow30", last30[0], 64'h3FFF_FFFF);
`endif
      release_ds();

      // Three back-to-back frames without release: burst, hold, drop.
      b0 = bursts; d0 = drop_cycles;
      send_frame(160, 2, 1'b0);
      send_frame(160, 3, 1'b0);
      send_frame(160, 4, 1'b1);
      tick(300);
      chk("t3_one_burst_held", bursts - b0, 1);
      chk("t3_pending_words", exp_q.size(), NI);
      chk("t3_drop_pulse_cycles", drop_cycles - d0, 1);
      release_ds();
      wait_idle(1000);
      chk("t3_bursts_after_done", bursts - b0, 2);

      // Short frame is discarded, following long frame bursts.
      release_ds();
      b0 = bursts; s0 = short_cycles;
      send_frame(100, 6, 1'b0);
      tick(50);
      chk("t4_no_burst_short", bursts - b0, 0);
      send_frame(200, 6, 1'b0);
      wait_idle(1000);
      chk("t4_bursts", bursts - b0, 1);
      chk("t4_short_pulse_cycles", short_cycles - s0, 1);

      // Reset mid-burst with a second frame arriving: everything is discarded.
      release_ds();
      send_frame(160, 7, 1'b0);
      fork
         send_frame(160, 2, 1'b0);
         begin
            c = 0;
            while (run_len < 50 && c < 400) begin tick(1); c++; end
            chk("t5_reached_word50", longint'(run_len >= 50), 1);
            abort = 1'b1; stop_send = 1'b1; rst_in = 1'b1;
            tick(1);
            rst_in = 1'b0;
            chk("t5_valid_low_after_rst", longint'(fft_valid), 0);
            chk("t5_data_zero_after_rst", longint'(fft_data), 0);
         end
      join
      clear_model();
      stop_send = 1'b0;
      tick(2);
      abort = 1'b0;
      tick(200);
      b0 = bursts;
      send_frame(160, 3, 1'b0);
      wait_idle(1000);
      chk("t5_burst_without_done", bursts - b0, 1);
      tick(300);
      chk("t5_no_stale_burst", bursts - b0, 1);

      // Four identical frames of p=1024 from a fresh reset.
`ifdef POWER_SMOOTH_EN
      exp6 = '{256, 448, 592, 700};
`else
      exp6 = '{1024, 1024, 1024, 1024};
`endif
      rst_in = 1'b1; tick(1); rst_in = 1'b0;
      clear_model();
      tick(200);
      for (int f = 0; f < 4; f++) begin
         send_frame(160, 5, 1'b0);
         wait_idle(1000);
         chk("t6_const_bin5", last_burst[5], exp6[f]);
         chk("t6_const_bin5_30", last30[5], exp6[f]);
         release_ds();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
